// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared types and constants for the systolic array sequencer.
//   sys_ctrl_state_t : sequencer FSM encoding (IDLE, CLEAR, FEED, DRAIN, DONE)
//   SYS_N_DEFAULT    : default array dimension
//   SYS_DW_DEFAULT   : default signed operand width
//   sat_inc32()      : saturating 32-bit increment used by the perf counter
// -----------------------------------------------------------------------------
package systolic_pkg;

   localparam int SYS_DW_DEFAULT = 8;
   localparam int SYS_N_DEFAULT  = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      FEED  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } sys_ctrl_state_t;

   // Increment that sticks at all-ones instead of wrapping to zero.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
   endfunction

endpackage

// File: rtl/systolic_ctrl_skew.sv
// -----------------------------------------------------------------------------
// systolic_ctrl_skew
// Purely combinational skew generator. For feed step t it selects, per lane,
// the operand that must enter the array edge at that step:
//   a_vec lane i = A[i][t-i] when 0 <= t-i < N, else 0
//   b_vec lane j = B[t-j][j] when 0 <= t-j < N, else 0
// Ports:
//   t       in  TW       feed step index
//   a_bank  in  N*N*DW   A bank, element [r][c] at bits [(r*N+c)*DW +: DW]
//   b_bank  in  N*N*DW   B bank, same layout
//   a_vec   out N*DW     row lanes for the array a_in edge
//   b_vec   out N*DW     column lanes for the array b_in edge
// -----------------------------------------------------------------------------
module systolic_ctrl_skew
   import systolic_pkg::*;
#(
   parameter int N  = SYS_N_DEFAULT,
   parameter int DW = SYS_DW_DEFAULT,
   parameter int TW = $clog2(2 * N)
) (
   input  logic [TW-1:0]     t,
   input  logic [N*N*DW-1:0] a_bank,
   input  logic [N*N*DW-1:0] b_bank,
   output logic [N*DW-1:0]   a_vec,
   output logic [N*DW-1:0]   b_vec
);

   // Lane i collects element k where i + k == t; at most one k matches per lane,
   // so OR-ing the masked candidates yields a plain mux with zero default.
   always_comb begin
      a_vec = '0;
      b_vec = '0;
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < N; k++) begin
            a_vec[i*DW +: DW] = a_vec[i*DW +: DW] |
                                ((t == TW'(i + k)) ? a_bank[(i*N + k)*DW +: DW] : {DW{1'b0}});
            b_vec[i*DW +: DW] = b_vec[i*DW +: DW] |
                                ((t == TW'(i + k)) ? b_bank[(k*N + i)*DW +: DW] : {DW{1'b0}});
         end
      end
   end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_seq_ctrl
// Sequencer for an N x N output-stationary systolic array. Holds operand banks
// A and B (loaded while idle), and on start runs CLEAR -> FEED (2N-1 skewed
// steps) -> DRAIN (DRAIN zero steps) -> DONE. All outputs are registered.
//
// Optional feature macro: SYSTOLIC_CTRL_PERF_EN
//   defined   : perf_cycles holds the busy length of the last completed run
//   undefined : perf_cycles is tied to zero
//
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   wr_en/wr_sel      bank write strobe, 0 = A, 1 = B (ignored while busy)
//   wr_row/wr_col     element index
//   wr_data           signed element
//   start             run request, level-sampled in IDLE and DONE
//   busy, done, clear run status, one-cycle done pulse, array clear
//   a_in, b_in        flattened skewed edges to the array
//   perf_cycles       cycle count of the last run
// -----------------------------------------------------------------------------
module systolic_seq_ctrl
   import systolic_pkg::*;
#(
   parameter int N     = SYS_N_DEFAULT,
   parameter int DW    = SYS_DW_DEFAULT,
   parameter int DRAIN = N + 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic                 wr_sel,
   input  logic [$clog2(N)-1:0] wr_row,
   input  logic [$clog2(N)-1:0] wr_col,
   input  logic [DW-1:0]        wr_data,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 clear,
   output logic [N*DW-1:0]      a_in,
   output logic [N*DW-1:0]      b_in,
   output logic [31:0]          perf_cycles
);

   localparam int AW  = $clog2(N);
   localparam int TW  = $clog2(2 * N);
   localparam int DCW = $clog2(DRAIN + 1);
   localparam logic [TW-1:0]  T_LAST = TW'(2 * N - 2);
   localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN - 1);

   // The DRAIN parameter shadows the imported state literal of the same name,
   // so state literals are referenced with the package scope throughout.
   sys_ctrl_state_t   state_r, state_nxt_s;
   logic [TW-1:0]     t_r, t_nxt_s;
   logic [DCW-1:0]    dcnt_r, dcnt_nxt_s;
   logic [N*N*DW-1:0] bank_a_r, bank_b_r;
   logic [N*DW-1:0]   skew_a_s, skew_b_s;
   logic              wr_ok_s;
   logic              busy_r, done_r, clear_r;
   logic [N*DW-1:0]   a_in_r, b_in_r;

   // Next-state and counter logic of the run sequencer.
   always_comb begin
      state_nxt_s = state_r;
      t_nxt_s     = t_r;
      dcnt_nxt_s  = dcnt_r;
      case (state_r)
         systolic_pkg::IDLE: begin
            if (start) begin
               state_nxt_s = systolic_pkg::CLEAR;
            end else begin
               state_nxt_s = systolic_pkg::IDLE;
            end
         end
         systolic_pkg::CLEAR: begin
            state_nxt_s = systolic_pkg::FEED;
            t_nxt_s     = '0;
         end
         systolic_pkg::FEED: begin
            if (t_r == T_LAST) begin
               state_nxt_s = systolic_pkg::DRAIN;
               dcnt_nxt_s  = '0;
            end else begin
               t_nxt_s = t_r + TW'(1);
            end
         end
         systolic_pkg::DRAIN: begin
            if (dcnt_r == D_LAST) begin
               state_nxt_s = systolic_pkg::DONE;
            end else begin
               dcnt_nxt_s = dcnt_r + DCW'(1);
            end
         end
         systolic_pkg::DONE: begin
            // Back-to-back run: start seen in DONE skips the IDLE cycle.
            if (start) begin
               state_nxt_s = systolic_pkg::CLEAR;
            end else begin
               state_nxt_s = systolic_pkg::IDLE;
            end
         end
         default: begin
            state_nxt_s = systolic_pkg::IDLE;
         end
      endcase
   end

   // Skew lanes are computed from the next step index so the registered edge
   // values line up with the FEED state cycle they belong to.
   systolic_ctrl_skew #(
      .N  (N),
      .DW (DW),
      .TW (TW)
   ) u_skew (
      .t      (t_nxt_s),
      .a_bank (bank_a_r),
      .b_bank (bank_b_r),
      .a_vec  (skew_a_s),
      .b_vec  (skew_b_s)
   );

   // Writes land only while idle; an IDLE write coinciding with start commits
   // at the same edge and is therefore seen by the run.
   assign wr_ok_s = wr_en & (state_r == systolic_pkg::IDLE);

   // State register and registered outputs derived from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= systolic_pkg::IDLE;
         t_r     <= '0;
         dcnt_r  <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         clear_r <= 1'b0;
         a_in_r  <= '0;
         b_in_r  <= '0;
      end else begin
         state_r <= state_nxt_s;
         t_r     <= t_nxt_s;
         dcnt_r  <= dcnt_nxt_s;
         busy_r  <= (state_nxt_s != systolic_pkg::IDLE);
         done_r  <= (state_nxt_s == systolic_pkg::DONE);
         clear_r <= (state_nxt_s == systolic_pkg::CLEAR);
         if (state_nxt_s == systolic_pkg::FEED) begin
            a_in_r <= skew_a_s;
            b_in_r <= skew_b_s;
         end else begin
            a_in_r <= '0;
            b_in_r <= '0;
         end
      end
   end

   // Operand banks; reset clears every element.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_a_r <= '0;
         bank_b_r <= '0;
      end else begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               if (wr_ok_s && (wr_row == AW'(r)) && (wr_col == AW'(c))) begin
                  if (wr_sel) begin
                     bank_b_r[(r*N + c)*DW +: DW] <= wr_data;
                  end else begin
                     bank_a_r[(r*N + c)*DW +: DW] <= wr_data;
                  end
               end
            end
         end
      end
   end

   assign busy  = busy_r;
   assign done  = done_r;
   assign clear = clear_r;
   assign a_in  = a_in_r;
   assign b_in  = b_in_r;

`ifdef SYSTOLIC_CTRL_PERF_EN
   logic [31:0] perf_cnt_r;
   logic [31:0] perf_cycles_r;
   logic        accept_s;

   assign accept_s = start & ((state_r == systolic_pkg::IDLE) | (state_r == systolic_pkg::DONE));

   // Busy-cycle counter; the DONE cycle itself is added when latching.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_cnt_r    <= 32'd0;
         perf_cycles_r <= 32'd0;
      end else begin
         if (accept_s) begin
            perf_cnt_r <= 32'd0;
         end else if (busy_r) begin
            perf_cnt_r <= sat_inc32(perf_cnt_r);
         end else begin
            perf_cnt_r <= perf_cnt_r;
         end
         if (state_r == systolic_pkg::DONE) begin
            perf_cycles_r <= sat_inc32(perf_cnt_r);
         end else begin
            perf_cycles_r <= perf_cycles_r;
         end
      end
   end

   assign perf_cycles = perf_cycles_r;
`else
   assign perf_cycles = 32'd0;
`endif

endmodule
